jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one bank of master-slave JK storage bits among NREQ requesters. Each requester presents a per-bit J/K command vector with a valid/ready handshake. The block grants one command at a time and applies it through a master stage, then a slave stage. It reports completion with a response pulse tagged with the requester index. It sits between control FSMs and the shared flag/status register bank.

Parameters:
NREQ, 4, number of requesters (2..8)
NBITS, 8, width of the shared JK bank
TOGGLE_EN, 0, J=K=1 behaviour: 0 = hold, 1 = toggle

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester command valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_j  input  NREQ*NBITS  J vectors; requester i occupies bits [i*NBITS +: NBITS]
req_k  input  NREQ*NBITS  K vectors; same packing as req_j
q  output  NBITS  slave (visible) bank state
qn  output  NBITS  complement of q, registered alongside q
rsp_valid  output  1  one-cycle pulse: command committed to q
rsp_id  output  $clog2(NREQ)  index of the requester whose command committed
busy  output  1  high while a command is in flight (state != IDLE)

Behaviour:
- Reset (clk, rst: synchronous, active-high):
  - state=IDLE; master=0; q=0; qn=all ones.
  - rsp_valid=0; rsp_id=0; rr_ptr=0; req_ready=0.
- FSM states: IDLE, MASTER, SLAVE.
- IDLE:
  - req_ready is combinational. Grant the first valid requester searching from rr_ptr upward, wrapping modulo NREQ.
  - On a handshake (valid&ready) with requester g:
    - capture req_j/req_k slice g into cmd_j/cmd_k; latch g into cur_id.
    - rr_ptr <= (g+1) mod NREQ.
    - go to MASTER.
  - No valid: stay in IDLE; rr_ptr unchanged.
- MASTER: update each master bit i from (cmd_j[i], cmd_k[i]):
  - 10: set to 1
  - 01: clear to 0
  - 00: hold
  - 11: hold if TOGGLE_EN=0; master <= ~q[i] if TOGGLE_EN=1
  - Then go to SLAVE.
- SLAVE:
  - q <= master; qn <= ~master; rsp_valid <= 1; rsp_id <= cur_id; go to IDLE.
- Timing:
  - Handshake at edge N. Master updates at edge N+1. q/qn and the rsp_valid pulse change at edge N+2.
  - Next grant earliest at edge N+3 (req_ready high in the cycle after the SLAVE edge).
  - Throughput: 1 command per 3 cycles.
- req_ready is 0 in MASTER and SLAVE. Requesters must hold valid and data stable until accepted; req_valid may drop before acceptance with no effect.
- busy=1 in MASTER and SLAVE.
- q changes only at the SLAVE edge. The master value is never visible on q mid-operation.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously asserted requester waits at most NREQ-1 other grants (no starvation).
- rr_ptr wraps NREQ-1 -> 0.
- Reset mid-operation (MASTER or SLAVE): the in-flight command is discarded, no rsp_valid is issued, and all registers return to reset values on that edge.
- Reset dominates any simultaneous handshake.

Test Plan:
- Reset: assert rst 2 cycles -> q=0x00, qn=0xFF, rsp_valid=0, busy=0, req_ready=0 with no valid; then req0 J=0xFF K=0x00 -> q=0xFF at handshake+2 edges, rsp_valid one pulse, rsp_id=0.
- JK encoding: q=0xF0; command J=0x0C K=0x30 -> q=0xCC. Then J=K=0x0F: TOGGLE_EN=0 -> q stays 0xCC; TOGGLE_EN=1 -> q=0xC3.
- Round-robin: all 4 requesters valid from reset -> grant order 0,1,2,3,0; handshakes spaced exactly 3 cycles apart; rsp_id sequence 0,1,2,3,0.
- Fairness/wrap: req3 and req1 continuously valid, rr_ptr=2 -> grants 3,1,3,1; req0 raises valid after grant to 3 -> it is served before the next grant to 3.
- Visibility: during MASTER, q still holds the old value (0x00 while master=0xFF); busy=1 in MASTER and SLAVE; req_ready=0 for all requesters.
- Reset mid-op: handshake then rst in the MASTER cycle -> q=0x00, no rsp_valid pulse, state IDLE; after rst deasserts, the still-valid requester is re-granted per rr_ptr=0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one master-slave JK bank among NREQ requesters.
// A granted command updates the master stage, then commits to the visible slave q one cycle later.

module jk_master_cell #(
  parameter int TOGGLE_EN = 0
) (
  input  logic j,
  input  logic k,
  input  logic m,
  input  logic q,
  output logic m_nxt
);
  always_comb begin
    case ({j, k})
      2'b10:   m_nxt = 1'b1;
      2'b01:   m_nxt = 1'b0;
      2'b11:   m_nxt = (TOGGLE_EN != 0) ? ~q : m;
      default: m_nxt = m;
    endcase
  end
endmodule

module jk_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int NBITS     = 8,
  parameter int TOGGLE_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*NBITS-1:0]    req_j,
  input  logic [NREQ*NBITS-1:0]    req_k,
  output logic [NBITS-1:0]         q,
  output logic [NBITS-1:0]         qn,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, MASTER, SLAVE} state_t;

  state_t                      state;
  logic [IDW-1:0]              rr_ptr, cur_id, gnt_id;
  logic [IDW:0]                cand;
  logic                        gnt_found, hs;
  logic [NBITS-1:0]            cmd_j, cmd_k, master, master_nxt;
  logic [NREQ-1:0][NBITS-1:0]  req_j_a, req_k_a;

  assign req_j_a = req_j;
  assign req_k_a = req_k;
  assign busy    = (state != IDLE);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int o = 0; o < NREQ; o++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(o);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[IDW-1:0];
      end
    end
  end

  // Reset dominates: no grant is offered while rst is high.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign hs = |(req_ready & req_valid);

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    jk_master_cell #(.TOGGLE_EN(TOGGLE_EN)) u_cell (
      .j     (cmd_j[b]),
      .k     (cmd_k[b]),
      .m     (master[b]),
      .q     (q[b]),
      .m_nxt (master_nxt[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      master    <= '0;
      q         <= '0;
      qn        <= '1;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cmd_j     <= '0;
      cmd_k     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          cmd_j  <= req_j_a[gnt_id];
          cmd_k  <= req_k_a[gnt_id];
          cur_id <= gnt_id;
          rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
          state  <= MASTER;
        end
        MASTER: begin
          master <= master_nxt;
          state  <= SLAVE;
        end
        SLAVE: begin
          q         <= master;
          qn        <= ~master;
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: hold-mode and toggle-mode instances share stimulus and are
// checked against a vector-level JK model and a modulo-scan round-robin model.

module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]             req_valid = '0;
  logic [NREQ-1:0][NBITS-1:0]  req_j = '0, req_k = '0;
  logic [NREQ-1:0]             ready0, ready1;
  logic [NBITS-1:0]            q0, qn0, q1, qn1;
  logic                        rv0, rv1, busy0, busy1;
  logic [IDW-1:0]              rid0, rid1;

  int checks = 0;
  int errors = 0;

  int              m_ptr;
  logic [NBITS-1:0] m_q0, m_q1;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TOGGLE_EN(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
    .req_j(req_j), .req_k(req_k), .q(q0), .qn(qn0),
    .rsp_valid(rv0), .rsp_id(rid0), .busy(busy0)
  );

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TOGGLE_EN(1)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_j(req_j), .req_k(req_k), .q(q1), .qn(qn1),
    .rsp_valid(rv1), .rsp_id(rid1), .busy(busy1)
  );

  function automatic int exp_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int o = 0; o < NREQ; o++)
      if (mask[(ptr + o) % NREQ]) return (ptr + o) % NREQ;
    return -1;
  endfunction

  function automatic logic [NBITS-1:0] jk_apply(input logic [NBITS-1:0] qv, j, k, input bit tog);
    logic [NBITS-1:0] both;
    both = j & k;
    return (qv & ~(j | k)) | (j & ~k) | (both & (tog ? ~qv : qv));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q0, qn0, q1, qn1} !== {8'h00, 8'hFF, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_q: got q/qn %h/%h %h/%h, want 00/ff 00/ff", q0, qn0, q1, qn1);
    end
    checks++;
    if ({rv0, rv1, busy0, busy1, ready0, ready1} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got rv %b%b busy %b%b ready %b %b, want all 0",
               rv0, rv1, busy0, busy1, ready0, ready1);
    end
    rst = 1'b0;
    m_ptr = 0;
    m_q0 = '0;
    m_q1 = '0;
  endtask

  // One full command: handshake, MASTER, SLAVE, commit. Ends #1 after the commit edge.
  task automatic run_cmd(input logic [NREQ-1:0] mask, input bit rnd);
    int g;
    logic [NREQ-1:0]  oh;
    logic [NBITS-1:0] n0, n1;
    req_valid = mask;
    #1;
    g = exp_grant(mask, m_ptr);
    oh = '0;
    oh[g] = 1'b1;
    checks++;
    if ({ready0, ready1} !== {oh, oh}) begin
      errors++;
      $display("FAIL grant: got ready %b/%b, want %b (ptr %0d)", ready0, ready1, oh, m_ptr);
    end
    n0 = jk_apply(m_q0, req_j[g], req_k[g], 1'b0);
    n1 = jk_apply(m_q1, req_j[g], req_k[g], 1'b1);
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      if (s == 0 && rnd) begin
        req_j[g] = NBITS'($urandom);
        req_k[g] = NBITS'($urandom);
      end
      checks++;
      if ({busy0, busy1, ready0, ready1, rv0, rv1, q0, q1} !==
          {2'b11, {2*NREQ{1'b0}}, 2'b00, m_q0, m_q1}) begin
        errors++;
        $display("FAIL inflight%0d: got busy %b%b ready %b/%b rv %b%b q %h/%h, want busy 11 ready 0 rv 00 q %h/%h",
                 s, busy0, busy1, ready0, ready1, rv0, rv1, q0, q1, m_q0, m_q1);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({q0, qn0, q1, qn1} !== {n0, ~n0, n1, ~n1}) begin
      errors++;
      $display("FAIL commit_q: got q/qn %h/%h %h/%h, want %h/%h %h/%h",
               q0, qn0, q1, qn1, n0, ~n0, n1, ~n1);
    end
    checks++;
    if ({rv0, rv1, rid0, rid1, busy0, busy1} !== {2'b11, IDW'(g), IDW'(g), 2'b00}) begin
      errors++;
      $display("FAIL rsp: got rv %b%b id %0d/%0d busy %b%b, want rv 11 id %0d busy 00",
               rv0, rv1, rid0, rid1, busy0, busy1, g);
    end
    m_q0 = n0;
    m_q1 = n1;
    m_ptr = (g + 1) % NREQ;
  endtask

  task automatic idle_cycle();
    req_valid = '0;
    #1;
    checks++;
    if ({ready0, ready1, busy0, busy1} !== '0) begin
      errors++;
      $display("FAIL idle_ready: got ready %b/%b busy %b%b, want 0", ready0, ready1, busy0, busy1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({q0, q1, rv0, rv1} !== {m_q0, m_q1, 2'b00}) begin
      errors++;
      $display("FAIL idle_hold: got q %h/%h rv %b%b, want q %h/%h rv 00", q0, q1, rv0, rv1, m_q0, m_q1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    req_j[0] = 8'hFF;
    req_k[0] = 8'h00;
    run_cmd(4'b0001, 1'b0);
    checks++;
    if (q0 !== 8'hFF) begin
      errors++;
      $display("FAIL first_cmd: got q %h, want ff", q0);
    end
  endtask

  task automatic test_jk_encoding();
    req_j[1] = 8'hF0; req_k[1] = 8'h0F;
    run_cmd(4'b0010, 1'b0);
    req_j[1] = 8'h0C; req_k[1] = 8'h30;
    run_cmd(4'b0010, 1'b0);
    checks++;
    if ({q0, q1} !== {8'hCC, 8'hCC}) begin
      errors++;
      $display("FAIL jk_setclr: got q %h/%h, want cc/cc", q0, q1);
    end
    req_j[1] = 8'h0F; req_k[1] = 8'h0F;
    run_cmd(4'b0010, 1'b0);
    checks++;
    if ({q0, q1} !== {8'hCC, 8'hC3}) begin
      errors++;
      $display("FAIL jk_both: got hold/toggle q %h/%h, want cc/c3", q0, q1);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_cmd(4'b1111, 1'b1);
      checks++;
      if (rid0 !== IDW'(exp_seq[i])) begin
        errors++;
        $display("FAIL rr_order[%0d]: got id %0d, want %0d", i, rid0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] masks[5] = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011};
    int exp_seq[5] = '{3, 1, 3, 0, 1};
    do_reset();
    run_cmd(4'b0001, 1'b1);
    run_cmd(4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_cmd(masks[i], 1'b1);
      checks++;
      if (rid0 !== IDW'(exp_seq[i])) begin
        errors++;
        $display("FAIL fair_order[%0d]: got id %0d, want %0d", i, rid0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_j[1] = 8'h5A; req_k[1] = 8'hA5;
    run_cmd(4'b0010, 1'b0);
    req_j[2] = 8'hFF; req_k[2] = 8'h00;
    req_valid = 4'b1100;
    #1;
    checks++;
    if (ready0 !== 4'b0100) begin
      errors++;
      $display("FAIL midop_grant: got ready %b, want 0100", ready0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({q0, qn0, q1, qn1, rv0, rv1, busy0, busy1} !== {8'h00, 8'hFF, 8'h00, 8'hFF, 4'b0000}) begin
      errors++;
      $display("FAIL midop_reset: got q/qn %h/%h %h/%h rv %b%b busy %b%b, want 00/ff 00/ff rv 00 busy 00",
               q0, qn0, q1, qn1, rv0, rv1, busy0, busy1);
    end
    m_ptr = 0;
    m_q0 = '0;
    m_q1 = '0;
    run_cmd(4'b1100, 1'b0);
    checks++;
    if ({rid0, q0} !== {IDW'(2), 8'hFF}) begin
      errors++;
      $display("FAIL midop_regrant: got id %0d q %h, want id 2 q ff", rid0, q0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else run_cmd(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);
    end
  endtask

  initial begin
    for (int r = 0; r < NREQ; r++) begin
      req_j[r] = NBITS'($urandom);
      req_k[r] = NBITS'($urandom);
    end
    test_reset();
    test_jk_encoding();
    test_round_robin();
    test_fairness();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
